// File: rtl/disp_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : disp_scan_ctrl_pkg
// Brief   : Shared constants for the 4-digit 7-segment scan controller.
// Revision: 1.0
// ============================================================================
package disp_scan_ctrl_pkg;

    localparam int NDIG = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low anode pattern selecting a single digit.
    function automatic logic [NDIG-1:0] an_select(input logic [1:0] idx);
        return ~(NDIG'(1) << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_scan_ctrl_hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_7seg
// Brief   : Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
// Revision: 1.0
// ============================================================================
module hex_to_7seg (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_nib)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : disp_scan_ctrl
// Brief   : Time-multiplexed scan controller for a 4-digit common-anode
//           7-segment display with frame-synchronous data commit.
// Revision: 1.0
// ============================================================================
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 12500,
    parameter int BLANK_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int              CW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   c_CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   c_BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam bit              c_NO_BLANK   = (BLANK_CYC == 0);
    localparam logic [1:0]      c_IDX_LAST   = 2'(NDIG - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;

    logic [15:0]   r_pend_digits;
    logic [3:0]    r_pend_dp;
    logic [3:0]    r_pend_blank;
    logic [15:0]   r_act_digits;
    logic [3:0]    r_act_dp;
    logic [3:0]    r_act_blank;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_commit;
    logic [3:0]    w_nib;
    logic [6:0]    w_dec;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_done;

    assign w_nib = r_act_digits[{r_idx, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign w_slot_end = (r_state == ST_DRIVE) && (r_cnt == c_CNT_LAST);

    // Next-state logic; cnt runs through the whole slot, blank phase included.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = c_NO_BLANK ? ST_DRIVE : ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == c_BLANK_LAST) begin
                        w_state_nxt = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                end else if (w_slot_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = c_NO_BLANK ? ST_DRIVE : ST_BLANK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        w_frame_end = w_slot_end && (r_idx == c_IDX_LAST) && en;
        w_commit    = ((r_state == ST_IDLE) && en) || w_frame_end;
        w_an        = AN_OFF;
        w_seg       = SEG_OFF;
        w_dp        = 1'b1;
        if (r_state == ST_DRIVE) begin
            w_seg = w_dec;
            w_dp  = ~r_act_dp[r_idx];
            if (!r_act_blank[r_idx]) begin
                w_an = an_select(r_idx);
            end
        end
    end

    // A load on a commit cycle bypasses pending so the new frame shows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_act_digits  <= '0;
            r_act_dp      <= '0;
            r_act_blank   <= '0;
        end else begin
            if (load) begin
                r_pend_digits <= digits;
                r_pend_dp     <= dp_mask;
                r_pend_blank  <= blank_mask;
            end
            if (w_commit) begin
                r_act_digits <= load ? digits     : r_pend_digits;
                r_act_dp     <= load ? dp_mask    : r_pend_dp;
                r_act_blank  <= load ? blank_mask : r_pend_blank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the calculator's 4-digit common-anode 7-segment display.
- Owns the shared segment/DP bus and schedules one digit at a time on it.
- Takes the BCD/hex result word, the decimal-point mask produced by the DP logic, and a per-digit blank mask.
- New values are committed only at frame boundaries, so a displayed frame never mixes old and new data.

Parameters:
CLK_DIV, 12500, clocks per digit slot (blank + drive); must be >= 2
BLANK_CYC, 256, clocks at start of each slot with all anodes off (anti-ghosting); 0 <= BLANK_CYC < CLK_DIV

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  scan enable; 0 = display dark
load  input  1  one-cycle strobe; capture digits/dp_mask/blank_mask into the pending buffer
digits  input  16  four hex nibbles; [3:0] = digit 0 (rightmost)
dp_mask  input  4  1 = decimal point lit on digit i
blank_mask  input  4  1 = digit i suppressed
an  output  4  anode enables, active low
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low
frame_done  output  1  one-cycle pulse at the end of each full frame

Behaviour:
- Reset (async, active-high):
  - an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
  - State=IDLE; slot counter cnt=0; digit index idx=0.
  - Pending and active buffers cleared to 0.
- Buffers:
  - pending is written on any cycle with load=1, in any state.
  - active drives the display; it is copied from pending only at commit points.
- States: IDLE, BLANK, DRIVE.
- IDLE:
  - Outputs dark.
  - When en=1: commit pending to active; idx=0; cnt=0.
  - Next state is BLANK, or DRIVE directly if BLANK_CYC=0.
- BLANK:
  - Anodes off; cnt increments each clock.
  - When cnt==BLANK_CYC-1, go to DRIVE.
- DRIVE:
  - an[idx]=0 unless active blank_mask[idx]=1 (then all anodes stay off).
  - seg = hex decode of active nibble idx.
  - dp = ~active dp_mask[idx].
  - When cnt==CLK_DIV-1: cnt=0; idx=idx+1 mod 4; go to BLANK, or stay in DRIVE if BLANK_CYC=0.
- Frame end (DRIVE, cnt==CLK_DIV-1, idx==3):
  - frame_done=1 for exactly that cycle (registered, asserted on the following clock edge).
  - Commit pending to active.
- Load coinciding with a commit point (frame end or IDLE exit):
  - The loaded data bypasses pending and goes directly to active.
  - It is visible from slot 0 of the next frame.
- en deasserted in any non-IDLE state:
  - Next state is IDLE; cnt and idx cleared.
  - Pending is retained; a partial frame gives no frame_done.
- an/seg/dp are registered: pins reflect the internal state with 1 clock latency.
- Decode covers 0-F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Timing:
  - Frame period = 4*CLK_DIV clocks.
  - cnt width = clog2(CLK_DIV); idx is 2 bits and wraps naturally.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE/ST_BLANK/ST_DRIVE.
  - NDIG=4.
  - SEG_OFF=7'b1111111 and AN_OFF=4'b1111.
- One sub-module, hex_to_7seg: purely combinational, 4-bit in, 7-bit active-low out, using the table above.

Test Plan (CLK_DIV=8, BLANK_CYC=2; frame = 32 clocks):
1. Reset asserted mid-run -> same cycle: an=1111, seg=1111111, dp=1, frame_done=0; held until rst falls.
2. load digits=16'h1234, dp_mask=4'b0100, blank_mask=0, then en=1:
   - Slot 0: 2 clocks dark, then an=1110, seg=0011001 ('4'), dp=1.
   - Slot 2: an=1011, seg=0100100 ('2'), dp=0.
   - frame_done pulses every 32 clocks.
3. Mid-frame load of 16'hABCD during slot 1 -> remainder of frame still shows 1234; after frame_done, slot 0 shows 'd' (0100001).
4. blank_mask=4'b1000 -> an[3] never 0 across 3 frames; slot-3 timing and frame_done period unchanged.
5. en dropped during slot 2 -> an=1111 within 2 clocks; no frame_done. Re-raise en -> scan restarts at slot 0 with pending data.
6. load of 16'h0F00 in the frame_done cycle -> the next frame's slot 2 shows 'F' (0001110); the prior pending value is never displayed.
